uart_imem_loader: RTL and testbench

//   Boot-time sequencer between the UART receiver and the instruction memory.
//   - Assembles received bytes, little-endian, into 32-bit instruction words.
//   - Writes each word to consecutive imem word addresses.
//   - Holds the CPU in reset until the host sends the end-of-program marker.
//   - Then raises write_done and releases the core.
//

---
 rtl/uart_imem_loader.sv | 166 ++++++++++++++++
 tb/tb_uart_imem_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//
// Boot-time sequencer that sits between the UART receiver and the
// instruction memory. Received bytes are packed little-endian into 32-bit
// words and written to consecutive imem word addresses. The core is held in
// reset until the host sends END_COUNT consecutive END_WORD terminators.
// After that, write_done rises and cpu_rst falls.
//
// Ports:
//   clk            system clock
//   resetn         asynchronous active-low reset
//   uart_rx_valid  one-cycle pulse, uart_rx_data holds a received byte
//   uart_rx_data   received byte
//   uart_rx_break  BREAK on the line; restarts the load from address 0
//   imem_we        imem write strobe, one cycle per completed word
//   imem_addr      imem word address (held between writes)
//   imem_wdata     imem write data (held between writes)
//   cpu_rst        active-high core reset, high while loading
//   write_done     program loaded, core running
//   load_err       sticky, program did not fit in DEPTH words

module uart_imem_loader #(
  parameter int          ADDR_W      = 8,
  parameter int          DEPTH       = 256,
  parameter logic [31:0] END_WORD    = 32'hFFFF_FFFF,
  parameter int          END_COUNT   = 2,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              write_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(END_COUNT + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {
    LOAD,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  // One bit wider than imem_addr so that addr can reach DEPTH when
  // DEPTH == 2**ADDR_W and the overflow condition is still visible.
  logic [ADDR_W:0]  addr;
  logic [CNT_W-1:0] end_cnt;
  logic [TMR_W-1:0] idle_tmr;
  logic             done_pend;

  logic             accept;
  logic             word_full;
  logic [31:0]      full_word;
  logic             is_end;
  logic [CNT_W-1:0] end_cnt_nxt;
  logic             room;
  logic             timeout;

  // Break outranks byte acceptance, which outranks the idle timeout.
  assign accept      = (state == LOAD) && uart_rx_valid && !uart_rx_break;
  assign word_full   = accept && (byte_cnt == 2'd3);
  assign full_word   = {uart_rx_data, word_buf};
  assign is_end      = (full_word == END_WORD);
  assign end_cnt_nxt = is_end ? end_cnt + CNT_W'(1) : '0;
  assign room        = (addr < (ADDR_W + 1)'(DEPTH));
  assign timeout     = (state == LOAD) && (byte_cnt != 2'd0) && !uart_rx_valid &&
                       !uart_rx_break && (idle_tmr == TMR_W'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and core-control outputs. done_pend is raised on the edge
  // that schedules the final write (or drops an overflowing word), so the
  // move to DONE lands one cycle after that write strobe.
  always_comb begin
    state_nxt  = state;
    cpu_rst    = 1'b1;
    write_done = 1'b0;
    case (state)
      LOAD: begin
        if (done_pend) state_nxt = DONE;
      end
      DONE: begin
        cpu_rst    = 1'b0;
        write_done = 1'b1;
      end
      default: state_nxt = LOAD;
    endcase
    if (uart_rx_break) state_nxt = LOAD;
  end

  // Byte assembly, word write, termination, overflow and idle timeout.
  // The fourth byte is not stored in word_buf. It goes straight into
  // imem_wdata together with the three buffered lanes, so the write strobe
  // appears in the very next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_cnt   <= 2'd0;
      word_buf   <= '0;
      addr       <= '0;
      end_cnt    <= '0;
      idle_tmr   <= '0;
      done_pend  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_err   <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      done_pend <= 1'b0;
      if (uart_rx_break) begin
        byte_cnt <= 2'd0;
        addr     <= '0;
        end_cnt  <= '0;
        idle_tmr <= '0;
        load_err <= 1'b0;
      end else if (accept) begin
        idle_tmr <= '0;
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: word_buf[7:0]   <= uart_rx_data;
          2'd1: word_buf[15:8]  <= uart_rx_data;
          2'd2: word_buf[23:16] <= uart_rx_data;
          default: begin
            if (word_full && room) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr[ADDR_W-1:0];
              imem_wdata <= full_word;
              addr       <= addr + (ADDR_W + 1)'(1);
              end_cnt    <= end_cnt_nxt;
              if (end_cnt_nxt == CNT_W'(END_COUNT)) done_pend <= 1'b1;
            end else begin
              load_err  <= 1'b1;
              done_pend <= 1'b1;
            end
          end
        endcase
      end else if (timeout) begin
        // Partial word is abandoned. addr and end_cnt are left alone.
        byte_cnt <= 2'd0;
        idle_tmr <= '0;
      end else if ((state == LOAD) && (byte_cnt != 2'd0)) begin
        idle_tmr <= idle_tmr + TMR_W'(1);
      end else begin
        idle_tmr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader
//
// Directed bench for uart_imem_loader, built with DEPTH=4, TIMEOUT_CYC=50,
// END_COUNT=2. Bytes are driven on the falling edge and outputs are
// sampled on the falling edge. Every write strobe seen on the rising edge
// is copied into a shadow imem so that the written contents can be compared
// with hand-computed words.

`timescale 1ns/1ps

module tb_uart_imem_loader;

  logic        clk;
  logic        resetn;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_break;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        write_done;
  logic        load_err;

  logic [31:0] mem [0:255];
  int          we_count;
  int          bad_count;
  logic        watch;
  int          check_count;
  int          pass_count;
  int          we_base;
  int          bad_base;

  uart_imem_loader #(
    .ADDR_W      (8),
    .DEPTH       (4),
    .END_WORD    (32'hFFFF_FFFF),
    .END_COUNT   (2),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_break (uart_rx_break),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .cpu_rst       (cpu_rst),
    .write_done    (write_done),
    .load_err      (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow imem plus a running count of write strobes.
  initial we_count = 0;
  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      we_count++;
    end
  end

  // Counts cycles where the core is released while a load is being watched.
  initial bad_count = 0;
  always @(posedge clk) begin
    if (watch && (write_done || !cpu_rst)) bad_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic applyWord(input logic [31:0] w);
    applyStimulus(w[7:0]);
    applyStimulus(w[15:8]);
    applyStimulus(w[23:16]);
    applyStimulus(w[31:24]);
  endtask

  task automatic applyBreak();
    @(negedge clk);
    uart_rx_break = 1'b1;
    @(negedge clk);
    uart_rx_break = 1'b0;
  endtask

  initial begin
    check_count   = 0;
    pass_count    = 0;
    watch         = 1'b0;
    resetn        = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_break = 1'b0;

    #3;
    checkOutput("rst_we",    {31'd0, imem_we},    32'd0);
    checkOutput("rst_addr",  {24'd0, imem_addr},  32'd0);
    checkOutput("rst_wdata", imem_wdata,          32'd0);
    checkOutput("rst_cpu",   {31'd0, cpu_rst},    32'd1);
    checkOutput("rst_done",  {31'd0, write_done}, 32'd0);
    checkOutput("rst_err",   {31'd0, load_err},   32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Test 1: one instruction then two terminators.
    we_base = we_count;
    applyWord(32'hFD01_0113);
    applyWord(32'hFFFF_FFFF);
    applyWord(32'hFFFF_FFFF);
    checkOutput("t1_we_last",  {31'd0, imem_we},    32'd1);
    checkOutput("t1_done_early", {31'd0, write_done}, 32'd0);
    @(negedge clk);
    checkOutput("t1_done",  {31'd0, write_done}, 32'd1);
    checkOutput("t1_cpu",   {31'd0, cpu_rst},    32'd0);
    checkOutput("t1_mem0",  mem[0], 32'hFD01_0113);
    checkOutput("t1_mem1",  mem[1], 32'hFFFF_FFFF);
    checkOutput("t1_mem2",  mem[2], 32'hFFFF_FFFF);
    applyWord(32'h1234_5678);
    repeat (2) @(negedge clk);
    checkOutput("t1_we_cnt", we_count - we_base, 32'd3);

    // Test 2: a lone terminator does not finish the load.
    applyBreak();
    checkOutput("brk_cpu",  {31'd0, cpu_rst},    32'd1);
    checkOutput("brk_done", {31'd0, write_done}, 32'd0);
    we_base = we_count;
    applyWord(32'hFFFF_FFFF);
    applyWord(32'h0000_0013);
    repeat (3) @(negedge clk);
    checkOutput("t2_not_done", {31'd0, write_done}, 32'd0);
    applyWord(32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    checkOutput("t2_not_done2", {31'd0, write_done}, 32'd0);
    applyWord(32'hFFFF_FFFF);
    checkOutput("t2_addr3", {24'd0, imem_addr}, 32'd3);
    @(negedge clk);
    checkOutput("t2_done",   {31'd0, write_done}, 32'd1);
    checkOutput("t2_err",    {31'd0, load_err},   32'd0);
    checkOutput("t2_mem1",   mem[1], 32'h0000_0013);
    checkOutput("t2_we_cnt", we_count - we_base, 32'd4);

    // Test 3: partial word discarded by timeout, then a word completed
    // after an idle gap shorter than the timeout.
    applyBreak();
    we_base = we_count;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (60) @(negedge clk);
    checkOutput("t3_no_we", we_count - we_base, 32'd0);
    applyWord(32'hDDCC_BBAA);
    @(negedge clk);
    checkOutput("t3_mem0",   mem[0], 32'hDDCC_BBAA);
    checkOutput("t3_addr0",  {24'd0, imem_addr}, 32'd0);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    repeat (44) @(negedge clk);
    applyStimulus(8'h04);
    @(negedge clk);
    checkOutput("t3_mem1",   mem[1], 32'h0403_0201);
    checkOutput("t3_we_cnt", we_count - we_base, 32'd2);

    // Test 4: overflow at DEPTH=4.
    applyBreak();
    we_base = we_count;
    applyWord(32'h0000_0001);
    applyWord(32'h0000_0002);
    applyWord(32'h0000_0003);
    applyWord(32'h0000_0004);
    checkOutput("t4_addr3", {24'd0, imem_addr}, 32'd3);
    applyWord(32'h0000_0005);
    checkOutput("t4_no_we",     {31'd0, imem_we},    32'd0);
    checkOutput("t4_err",       {31'd0, load_err},   32'd1);
    checkOutput("t4_done_early", {31'd0, write_done}, 32'd0);
    @(negedge clk);
    checkOutput("t4_done",   {31'd0, write_done}, 32'd1);
    checkOutput("t4_mem3",   mem[3], 32'h0000_0004);
    checkOutput("t4_we_cnt", we_count - we_base, 32'd4);

    // Test 5: break in the middle of a load restarts from address 0.
    applyBreak();
    checkOutput("t5_err_clr", {31'd0, load_err}, 32'd0);
    we_base  = we_count;
    bad_base = bad_count;
    watch    = 1'b1;
    applyWord(32'h1111_1111);
    applyWord(32'h2222_2222);
    applyBreak();
    applyWord(32'hAAAA_0001);
    applyWord(32'hFFFF_FFFF);
    applyWord(32'hFFFF_FFFF);
    watch = 1'b0;
    checkOutput("t5_addr2", {24'd0, imem_addr}, 32'd2);
    @(negedge clk);
    checkOutput("t5_mem0",    mem[0], 32'hAAAA_0001);
    checkOutput("t5_bad",     bad_count - bad_base, 32'd0);
    checkOutput("t5_we_cnt",  we_count - we_base,   32'd5);
    checkOutput("t5_done",    {31'd0, write_done}, 32'd1);

    // Test 6: asynchronous reset in the middle of a word.
    applyBreak();
    applyStimulus(8'h99);
    applyStimulus(8'h88);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t6_addr",  {24'd0, imem_addr},  32'd0);
    checkOutput("t6_wdata", imem_wdata,          32'd0);
    checkOutput("t6_cpu",   {31'd0, cpu_rst},    32'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    we_base = we_count;
    applyWord(32'h1234_5678);
    @(negedge clk);
    checkOutput("t6_mem0",   mem[0], 32'h1234_5678);
    checkOutput("t6_addr0",  {24'd0, imem_addr}, 32'd0);
    checkOutput("t6_we_cnt", we_count - we_base, 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
